// File: rtl/sound_tone_gen.sv
// Buzzer tone generator: picks one of hit/wall/goal by fixed priority and drives a
// square wave whose half-period depends on the tone (goal warbles between two pitches).
module sound_tone_gen #(
  parameter int CNT_W         = 24,
  parameter int HIT_HALF      = 50000,
  parameter int WALL_HALF     = 100000,
  parameter int GOAL_HALF_A   = 25000,
  parameter int GOAL_HALF_B   = 37500,
  parameter int WARBLE_CYCLES = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_hit_en,
  input  logic       i_wall_en,
  input  logic       i_goal_en,
  output logic       o_audio_out,
  output logic       o_active,
  output logic [1:0] o_tone_sel
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALL = 2'd1,
    S_HIT  = 2'd2,
    S_GOAL = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_halfCnt;
  logic [CNT_W-1:0] r_warbleCnt;
  logic             r_phaseB;
  logic [CNT_W-1:0] w_curHalf;
  logic             w_halfWrap;
  logic             w_warbleWrap;

  always_comb begin
    w_next = S_IDLE;
    if (i_goal_en)      w_next = S_GOAL;
    else if (i_hit_en)  w_next = S_HIT;
    else if (i_wall_en) w_next = S_WALL;
  end

  always_comb begin
    w_curHalf = CNT_W'(HIT_HALF);
    case (r_state)
      S_WALL:  w_curHalf = CNT_W'(WALL_HALF);
      S_HIT:   w_curHalf = CNT_W'(HIT_HALF);
      S_GOAL:  w_curHalf = r_phaseB ? CNT_W'(GOAL_HALF_B) : CNT_W'(GOAL_HALF_A);
      default: w_curHalf = CNT_W'(HIT_HALF);
    endcase
  end

  // >= rather than == so a pitch switch to a shorter half-period ends the current half at once
  assign w_halfWrap   = (r_halfCnt >= (w_curHalf - CNT_W'(1)));
  assign w_warbleWrap = (r_warbleCnt >= CNT_W'(WARBLE_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_halfCnt   <= '0;
      r_warbleCnt <= '0;
      r_phaseB    <= 1'b0;
      o_audio_out <= 1'b0;
      o_active    <= 1'b0;
      o_tone_sel  <= 2'd0;
    end else begin
      r_state    <= w_next;
      o_tone_sel <= w_next;
      o_active   <= (w_next != S_IDLE);
      // Any tone change (including entering idle) restarts the waveform from a clean low
      if ((w_next != r_state) || (w_next == S_IDLE)) begin
        r_halfCnt   <= '0;
        r_warbleCnt <= '0;
        r_phaseB    <= 1'b0;
        o_audio_out <= 1'b0;
      end else begin
        if (w_halfWrap) begin
          r_halfCnt   <= '0;
          o_audio_out <= ~o_audio_out;
        end else begin
          r_halfCnt <= r_halfCnt + CNT_W'(1);
        end
        if (r_state == S_GOAL) begin
          if (w_warbleWrap) begin
            r_warbleCnt <= '0;
            r_phaseB    <= ~r_phaseB;
          end else begin
            r_warbleCnt <= r_warbleCnt + CNT_W'(1);
          end
        end else begin
          r_warbleCnt <= '0;
          r_phaseB    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_tone_gen.sv
// Directed bench for sound_tone_gen with short half-periods so every tone
// pattern, the goal warble and the priority/restart behaviour fit in a few hundred cycles.
module tb_sound_tone_gen;

  logic       clk;
  logic       rst;
  logic       hit_en;
  logic       wall_en;
  logic       goal_en;
  logic       audio_out;
  logic       active;
  logic [1:0] tone_sel;

  int vectors = 0;
  int errors  = 0;

  sound_tone_gen #(
    .CNT_W        (24),
    .HIT_HALF     (4),
    .WALL_HALF    (6),
    .GOAL_HALF_A  (2),
    .GOAL_HALF_B  (3),
    .WARBLE_CYCLES(20)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_hit_en   (hit_en),
    .i_wall_en  (wall_en),
    .i_goal_en  (goal_en),
    .o_audio_out(audio_out),
    .o_active   (active),
    .o_tone_sel (tone_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectOut(input string name, input logic expAudio,
                           input logic expActive, input logic [1:0] expSel);
    vectors++;
    if ({audio_out, active, tone_sel} !== {expAudio, expActive, expSel}) begin
      errors++;
      $display("[TB] FAIL %s: got audio=%b active=%b sel=%0d, expected audio=%b active=%b sel=%0d",
               name, audio_out, active, tone_sel, expAudio, expActive, expSel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hit_en = 1'b0; wall_en = 1'b0; goal_en = 1'b0;
    #3;
    expectOut("reset_initial", 1'b0, 1'b0, 2'd0);
    hit_en = 1'b1;
    tick();
    expectOut("reset_held", 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    expectOut("reset_pre_hit", 1'b1, 1'b1, 2'd2);
    #2 rst = 1'b1;
    #1;
    expectOut("reset_async_mid", 1'b0, 1'b0, 2'd0);
    #1 rst = 1'b0;
    hit_en = 1'b0;
    tick();
    tick();
    expectOut("reset_idle_after", 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_hit();
    hit_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      expectOut($sformatf("hit_edge%0d", k), 1'(((k - 1) / 4) % 2), 1'b1, 2'd2);
    end
    hit_en = 1'b0;
    tick();
    expectOut("hit_release", 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_priority();
    wall_en = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    expectOut("prio_wall_edge10", 1'b1, 1'b1, 2'd1);
    hit_en = 1'b1;
    tick();
    expectOut("prio_hit_edge11", 1'b0, 1'b1, 2'd2);
    for (int k = 12; k <= 14; k++) tick();
    expectOut("prio_hit_edge14", 1'b0, 1'b1, 2'd2);
    tick();
    expectOut("prio_hit_edge15", 1'b1, 1'b1, 2'd2);
    hit_en = 1'b0;
    tick();
    expectOut("prio_wall_restart16", 1'b0, 1'b1, 2'd1);
    for (int k = 17; k <= 21; k++) tick();
    expectOut("prio_wall_edge21", 1'b0, 1'b1, 2'd1);
    tick();
    expectOut("prio_wall_edge22", 1'b1, 1'b1, 2'd1);
    wall_en = 1'b0;
    tick();
    expectOut("prio_release", 1'b0, 1'b0, 2'd0);
  endtask

  // All three enables together: only the goal warble may appear
  task automatic test_goal_warble();
    int toggles[$];
    int count;
    toggles = '{2, 4, 6, 8, 10, 12, 14, 16, 18, 20,
                23, 26, 29, 32, 35, 38, 41, 43, 45};
    goal_en = 1'b1; hit_en = 1'b1; wall_en = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      tick();
      count = 0;
      foreach (toggles[i]) if (toggles[i] <= k - 1) count++;
      expectOut($sformatf("goal_edge%0d", k), 1'(count % 2), 1'b1, 2'd3);
    end
  endtask

  task automatic test_release();
    goal_en = 1'b0; hit_en = 1'b0; wall_en = 1'b0;
    tick();
    expectOut("release_edge1", 1'b0, 1'b0, 2'd0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      expectOut($sformatf("idle_flat%0d", k), 1'b0, 1'b0, 2'd0);
    end
  endtask

  task automatic test_back_to_back();
    hit_en = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    goal_en = 1'b1;
    tick();
    expectOut("b2b_goal_entry", 1'b0, 1'b1, 2'd3);
    tick();
    tick();
    expectOut("b2b_goal_toggle", 1'b1, 1'b1, 2'd3);
    goal_en = 1'b0;
    tick();
    expectOut("b2b_hit_restart", 1'b0, 1'b1, 2'd2);
    for (int k = 2; k <= 4; k++) tick();
    expectOut("b2b_hit_edge4", 1'b0, 1'b1, 2'd2);
    tick();
    expectOut("b2b_hit_edge5", 1'b1, 1'b1, 2'd2);
    hit_en = 1'b0;
    tick();
    expectOut("b2b_release", 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    test_reset();
    test_hit();
    test_priority();
    test_goal_warble();
    test_release();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
